// File: rtl/data_mem_responder.sv
// Single-ported word memory answering one byte-addressed load/store at a time,
// with a fixed response latency, abort on request withdrawal and read-before-write data.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  write_i,
   output logic [31:0] data_o,
   output logic        valid_o
);

   localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        access;

   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_mask;
   logic [IdxW-1:0] idx;
   logic [1:0]  off;
   logic [4:0]  sh;
   logic [31:0] rd_word;
   logic [31:0] wr_data_sh;
   logic [3:0]  wr_lanes;
   logic        unused_addr_bits;

   logic [31:0] mem [DEPTH_WORDS];

   // With LATENCY=1 the memory is accessed on the acceptance edge, before the latches load.
   always_comb begin
      if (state_q == StIdle) begin
         acc_addr  = addr_i;
         acc_wdata = data_i;
         acc_mask  = write_i;
      end else begin
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_mask  = wmask_q;
      end
   end

   assign idx              = acc_addr[IdxW+1:2];
   assign off              = acc_addr[1:0];
   assign sh               = {off, 3'b000};
   assign rd_word          = mem[idx];
   assign wr_data_sh       = acc_wdata << sh;
   assign wr_lanes         = acc_mask << off;
   assign unused_addr_bits = ^acc_addr[31:IdxW+2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      data_d  = data_q;
      valid_d = 1'b0;
      access  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en_i) begin
               addr_d  = addr_i;
               wdata_d = data_i;
               wmask_d = write_i;
               if (LATENCY == 1) begin
                  state_d = StResp;
                  access  = 1'b1;
               end else begin
                  state_d = StBusy;
                  cnt_d   = CntLoad;
               end
            end
         end
         StBusy: begin
            if (!en_i) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               state_d = StResp;
               cnt_d   = 4'd0;
               access  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase

      // Response carries the pre-write word, shifted down to the addressed byte.
      if (access) begin
         data_d  = rd_word >> sh;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wmask_q <= 4'd0;
         data_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Array has no reset; a write is only committed when no reset is applied.
   always_ff @(posedge clk) begin
      if (!rst_i && access) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_lanes[b]) begin
               mem[idx][8*b +: 8] <= wr_data_sh[8*b +: 8];
            end
         end
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 3, 1; 16 words) driven by
// a vector table plus hand-written abort, reset and back-to-back sequences.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic [2:0]  en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic [31:0] dout [3];
   logic [2:0]  valid;

   int n_tests;
   int n_fail;
   int vcnt [3];
   int exp_vcnt [3];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int          sel;
      logic        chk;
      logic [31:0] exp;
   } sb_t;

   sb_t  sbq [$];
   vec_t tbl [21];

   data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(2)) u_dut0 (
      .clk(clk), .rst_i(rst), .en_i(en[0]), .addr_i(addr), .data_i(wdata),
      .write_i(wmask), .data_o(dout[0]), .valid_o(valid[0])
   );
   data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_dut1 (
      .clk(clk), .rst_i(rst), .en_i(en[1]), .addr_i(addr), .data_i(wdata),
      .write_i(wmask), .data_o(dout[1]), .valid_o(valid[1])
   );
   data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut2 (
      .clk(clk), .rst_i(rst), .en_i(en[2]), .addr_i(addr), .data_i(wdata),
      .write_i(wmask), .data_o(dout[2]), .valid_o(valid[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (valid[i] === 1'b1) vcnt[i]++;
      end
   end

   function automatic int lat_of(input int sel);
      case (sel)
         0:       return 2;
         1:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                               input logic c, input logic [31:0] e);
      vec_t v;
      v.addr = a; v.data = d; v.mask = m; v.chk = c; v.exp = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following the response.
   task automatic run_txn(input int sel, input vec_t v, input string name);
      int   cyc;
      logic got;
      sb_t  e;
      sbq.push_back('{sel, v.chk, v.exp});
      exp_vcnt[sel]++;
      addr  = v.addr;
      wdata = v.data;
      wmask = v.mask;
      en[sel] = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (valid[sel] === 1'b1) got = 1'b1;
         else if (cyc == 1) begin
            addr  = $urandom;
            wdata = $urandom;
            wmask = 4'($urandom);
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout: no valid_o within %0d cycles, expected at %0d",
                  name, cyc, lat_of(sel));
         void'(sbq.pop_front());
      end else begin
         check({name, " latency"}, 32'(cyc), 32'(lat_of(sel)));
         e = sbq.pop_front();
         if (e.chk) check({name, " data"}, dout[e.sel], e.exp);
      end
      en[sel] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic ok;
      vec_t v;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 3; i++) begin
         vcnt[i] = 0;
         exp_vcnt[i] = 0;
      end

      tbl[0]  = mk(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      tbl[1]  = mk(32'h10, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF);
      tbl[2]  = mk(32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0);
      tbl[3]  = mk(32'h23, 32'h000000AA, 4'h1, 1'b1, 32'h00000011);
      tbl[4]  = mk(32'h20, 32'h0,        4'h0, 1'b1, 32'hAA223344);
      tbl[5]  = mk(32'h23, 32'h0,        4'h0, 1'b1, 32'h000000AA);
      tbl[6]  = mk(32'h28, 32'h00000000, 4'hF, 1'b0, 32'h0);
      tbl[7]  = mk(32'h2C, 32'h55667788, 4'hF, 1'b0, 32'h0);
      tbl[8]  = mk(32'h2B, 32'h0000BEEF, 4'h3, 1'b1, 32'h00000000);
      tbl[9]  = mk(32'h28, 32'h0,        4'h0, 1'b1, 32'hEF000000);
      tbl[10] = mk(32'h2C, 32'h0,        4'h0, 1'b1, 32'h55667788);
      tbl[11] = mk(32'h12, 32'h0,        4'h0, 1'b1, 32'h0000DEAD);
      tbl[12] = mk(32'h11, 32'h0000CAFE, 4'h3, 1'b1, 32'h00DEADBE);
      tbl[13] = mk(32'h10, 32'h0,        4'h0, 1'b1, 32'hDECAFEEF);
      tbl[14] = mk(32'h04, 32'h01020304, 4'hF, 1'b0, 32'h0);
      tbl[15] = mk(32'h44, 32'h0,        4'h0, 1'b1, 32'h01020304);
      tbl[16] = mk(32'h44, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h01020304);
      tbl[17] = mk(32'h04, 32'h0,        4'h0, 1'b1, 32'hA5A5A5A5);
      tbl[18] = mk(32'hFFFFFF10, 32'h0,  4'h0, 1'b1, 32'hDECAFEEF);
      tbl[19] = mk(32'h10, 32'hDECAFEEF, 4'hF, 1'b1, 32'hDECAFEEF);
      tbl[20] = mk(32'h11, 32'h0,        4'h0, 1'b1, 32'h00DECAFE);

      rst = 1'b1; en = 3'b000; addr = 32'h0; wdata = 32'h0; wmask = 4'h0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset valid[%0d]", i), 32'(valid[i]), 32'd0);
         check($sformatf("reset data[%0d]", i), dout[i], 32'd0);
      end
      rst = 1'b0;

      for (int i = 0; i < 21; i++) run_txn(0, tbl[i], $sformatf("vec%0d", i));

      // Abort: en_i withdrawn in cycle 1 of a store (LATENCY=3).
      run_txn(1, mk(32'h40, 32'h0BADF00D, 4'hF, 1'b0, 32'h0), "abort_prep_st");
      run_txn(1, mk(32'h40, 32'h0,        4'h0, 1'b1, 32'h0BADF00D), "abort_prep_ld");
      addr = 32'h40; wdata = 32'hFFFFFFFF; wmask = 4'hF; en[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en[1] = 1'b0;
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (valid[1] !== 1'b0) ok = 1'b0;
      end
      check("abort no valid", 32'(ok), 32'd1);
      check("abort data held", dout[1], 32'h0BADF00D);
      run_txn(1, mk(32'h40, 32'h0, 4'h0, 1'b1, 32'h0BADF00D), "abort_reload");

      // Reset during BUSY, then a request in the first cycle after reset.
      run_txn(1, mk(32'h30, 32'h11111111, 4'hF, 1'b0, 32'h0), "rst_prep");
      addr = 32'h30; wdata = 32'h12345678; wmask = 4'hF; en[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; en[1] = 1'b0;
      @(negedge clk);
      check("rst busy valid", 32'(valid[1]), 32'd0);
      check("rst busy data", dout[1], 32'd0);
      rst = 1'b0;
      run_txn(1, mk(32'h30, 32'h0, 4'h0, 1'b1, 32'h11111111), "post_rst_ld");

      // Back-to-back with en_i held high (LATENCY=1).
      run_txn(2, mk(32'h08, 32'h00000077, 4'hF, 1'b0, 32'h0), "b2b_prep_st");
      run_txn(2, mk(32'h08, 32'h0, 4'h0, 1'b1, 32'h00000077), "b2b_prep_ld");
      addr = 32'h08; wdata = 32'h0; wmask = 4'h0; en[2] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check($sformatf("b2b valid c%0d", k), 32'(valid[2]), 32'(k % 2));
         if (k % 2 == 1) check($sformatf("b2b data c%0d", k), dout[2], 32'h00000077);
      end
      en[2] = 1'b0;
      exp_vcnt[2] += 5;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         check($sformatf("valid count[%0d]", i), 32'(vcnt[i]), 32'(exp_vcnt[i]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored; it SHALL be a power of two, >= 2.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to valid_o; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port en_i, input, 1 bit: request present, held by the initiator until valid_o.
REQ-006 SHALL have port addr_i, input, 32 bits: byte address.
REQ-007 SHALL have port data_i, input, 32 bits: store data, right-aligned (byte/half in the low lanes).
REQ-008 SHALL have port write_i, input, 4 bits: right-aligned byte-write mask; 0 means load.
REQ-009 SHALL have port data_o, output, 32 bits: right-aligned read data, registered.
REQ-010 SHALL have port valid_o, output, 1 bit: response strobe, one cycle wide.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-012 In IDLE with en_i=1, SHALL accept the request and latch addr_i, data_i, write_i. Later input changes SHALL be ignored for that transaction.
REQ-013 Acceptance cycle = cycle 0; valid_o SHALL be 1 in exactly cycle LATENCY.
  - LATENCY=1: IDLE->RESP.
  - Otherwise: IDLE->BUSY; a down-counter is loaded with LATENCY-1; BUSY->RESP when the counter reaches 1.
REQ-014 RESP SHALL last one cycle with valid_o=1, then go unconditionally to IDLE.
  - en_i seen in the next IDLE cycle is a new transaction, even if the inputs are unchanged.
  - A repeated store writes the same value again.
REQ-015 If en_i=0 in any BUSY cycle, SHALL abort and go to IDLE: no write, no valid_o, data_o unchanged.
REQ-016 Word index = latched addr[log2(DEPTH_WORDS)+1:2]. Upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-017 Byte offset off = latched addr[1:0].
REQ-018 Read: in the RESP transition, data_o SHALL be loaded with the stored word shifted right by 8*off, zero-filled at the top.
REQ-019 Write (mask != 0), on the same edge as REQ-018:
  - Effective mask = (write_i << off) truncated to 4 bits.
  - Effective data = data_i << 8*off.
  - Only the masked lanes SHALL be updated.
  - Lanes shifted beyond byte 3 SHALL be dropped, with no spill into the next word.
REQ-020 For a write, data_o SHALL carry the pre-write word per REQ-018 (read-before-write).
REQ-021 data_o SHALL hold its value between responses.
REQ-022 Memory contents SHALL be single-ported. Only the accepted transaction accesses the memory, and only on the RESP transition edge.
REQ-023 en_i=1 in RESP or BUSY SHALL NOT start a second transaction; one transaction is outstanding at most.

Reset
REQ-024 While rst_i=1 at a clock edge:
  - State SHALL be IDLE, the counter 0, valid_o=0, data_o=0.
  - Any in-flight transaction SHALL be discarded, and its write SHALL NOT be committed.
REQ-025 Memory array contents SHALL NOT be affected by reset; array power-up values are don't-care.
REQ-026 A request with en_i=1 in the first cycle after rst_i deasserts SHALL be accepted normally.

Verification
REQ-027 Word store then load:
  - Stimulus (LATENCY=2): store addr 0x10, data 0xDEADBEEF, mask 0xF; then load addr 0x10.
  - Response: valid_o at cycle 2 of each transaction; the load returns data_o=0xDEADBEEF.
REQ-028 Byte store at offset 3:
  - Stimulus: word 0x11223344 at 0x20; store byte 0xAA to 0x23 (mask 0x1); then load 0x20 and load 0x23.
  - Response: the loads return 0xAA223344 and 0x000000AA respectively.
REQ-029 Misaligned halfword store:
  - Stimulus: word 0x00000000; store 0xBEEF with mask 0x3 to addr 0x2B.
  - Response: the word becomes 0xEF000000; word 0x2C is unchanged.
REQ-030 Abort:
  - Stimulus (LATENCY=3): en_i dropped in cycle 1 of a store to 0x40.
  - Response: no valid_o; a later load of 0x40 returns the old value.
REQ-031 Reset during BUSY:
  - Stimulus: rst_i pulsed during BUSY of a store of 0x12345678.
  - Response: valid_o stays 0, data_o=0, and the target word is unchanged.
REQ-032 Back-to-back and wrap:
  - Stimulus: en_i held high continuously with LATENCY=1.
  - Response: valid_o every 2nd cycle.
  - Stimulus: address 4*DEPTH_WORDS+4.
  - Response: accesses word 1.
